// File: rtl/hbtxuart.sv
// hbtxuart: 8N1 UART transmitter fed by the hexbus console output arbiter.
// It shifts each byte out LSB first, and o_busy gives back-pressure upstream.
// Optional feature: define HBTXUART_CTS_EN to add the i_cts_n flow-control input.
module hbtxuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic       i_clk,
  input  logic       i_areset_n,
  input  logic       i_stb,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic       o_uart_tx
`ifdef HBTXUART_CTS_EN
  ,
  input  logic       i_cts_n
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state;
  logic [23:0] baud_cnt;
  logic [7:0]  shift_reg;
  logic [3:0]  bit_cnt;
  logic        cts_hold;
  logic        baud_zero;

`ifdef HBTXUART_CTS_EN
  logic [1:0] cts_sync;

  // Two-flop synchroniser for clear-to-send; it resets to "not clear".
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) cts_sync <= 2'b11;
    else             cts_sync <= {cts_sync[0], i_cts_n};
  end

  assign cts_hold = cts_sync[1];
`else
  assign cts_hold = 1'b0;
`endif

  assign baud_zero = (baud_cnt == '0);

  // Frame sequencer. The line level and busy are registered alongside the state.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      shift_reg <= '1;
      bit_cnt   <= '0;
      o_busy    <= 1'b0;
      o_uart_tx <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          o_uart_tx <= 1'b1;
          if (i_stb && !o_busy) begin
            shift_reg <= i_data;
            state     <= S_START;
            baud_cnt  <= CLOCKS_PER_BAUD - 24'd1;
            o_uart_tx <= 1'b0;
            o_busy    <= 1'b1;
          end else begin
            o_busy <= cts_hold;
          end
        end
        S_START: begin
          if (baud_zero) begin
            state     <= S_DATA;
            bit_cnt   <= '0;
            baud_cnt  <= CLOCKS_PER_BAUD - 24'd1;
            o_uart_tx <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        S_DATA: begin
          if (baud_zero) begin
            baud_cnt <= CLOCKS_PER_BAUD - 24'd1;
            if (bit_cnt == 4'd7) begin
              state     <= S_STOP;
              o_uart_tx <= 1'b1;
            end else begin
              bit_cnt   <= bit_cnt + 4'd1;
              shift_reg <= {1'b1, shift_reg[7:1]};
              // The line takes the next bit directly, so it does not wait for the shifted register.
              o_uart_tx <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        S_STOP: begin
          if (baud_zero) begin
            state  <= S_IDLE;
            o_busy <= cts_hold;
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hbtxuart.sv
// tb_hbtxuart: self-checking bench for hbtxuart with CLOCKS_PER_BAUD=4.
// It predicts every frame from the 8N1 bit rules.
module tb_hbtxuart;

  localparam int unsigned CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       stb;
  logic [7:0] data;
  logic       busy;
  logic       uart_tx;
`ifdef HBTXUART_CTS_EN
  logic       cts_n;
`endif

  int n_assert;
  int n_fail;

  hbtxuart #(.CLOCKS_PER_BAUD(24'd4)) dut (
    .i_clk      (clk),
    .i_areset_n (rst_n),
    .i_stb      (stb),
    .i_data     (data),
    .o_busy     (busy),
    .o_uart_tx  (uart_tx)
`ifdef HBTXUART_CTS_EN
    ,
    .i_cts_n    (cts_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The expected line level k clocks into a frame: start, then 8 data bits LSB first, then stop.
  function automatic logic frame_bit(input logic [7:0] d, input int unsigned k);
    int unsigned j;
    j = k / CPB;
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return logic'((d >> (j - 1)) & 8'h01);
  endfunction

  // This is called at a negedge. It presents d, waits (bounded) for the accept edge, and returns at cycle t+1.
  task automatic start_byte(input logic [7:0] d, output int unsigned waits);
    stb  = 1'b1;
    data = d;
    waits = 0;
    while (busy !== 1'b0 && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 300) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  // This starts at the negedge of cycle t+1. It checks all 10*CPB frame clocks, then the idle clock after them.
  task automatic run_frame(input logic [7:0] d, input string tag,
                           input int unsigned cts_from, input int unsigned cts_to);
    for (int unsigned k = 0; k < 10 * CPB; k++) begin
      chk({tag, "_line"}, uart_tx, frame_bit(d, k));
      chk({tag, "_busy"}, busy, 1'b1);
`ifdef HBTXUART_CTS_EN
      cts_n = (k >= cts_from && k < cts_to);
`endif
      @(negedge clk);
    end
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_idle_line"}, uart_tx, 1'b1);
  endtask

  initial begin
    int unsigned w;
    logic [7:0]  rb;
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    stb   = 1'b1;
    data  = 8'h41;
`ifdef HBTXUART_CTS_EN
    cts_n = 1'b0;
`endif

    // 1: reset is held while stb is high. The line stays static, and the byte is accepted right after release.
    repeat (5) begin
      @(negedge clk);
      chk("rst_line", uart_tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
    end
    rst_n = 1'b1;
`ifdef HBTXUART_CTS_EN
    start_byte(8'h41, w);
`else
    start_byte(8'h41, w);
    chk("rst_first_accept", w, 32'd0);
`endif
    stb = 1'b0;
    // 2: a single 8'h41 frame.
    run_frame(8'h41, "f41", 0, 0);

    // 3: 8'h55 and then 8'hAA are sent back to back with stb held high.
    start_byte(8'h55, w);
    data = 8'hAA;
    run_frame(8'h55, "f55", 0, 0);
    @(negedge clk);
    stb = 1'b0;
    run_frame(8'hAA, "fAA", 0, 0);

    // 4: data changes to FF during the 0F frame. The 0F frame is unchanged, and FF goes out only after it.
    start_byte(8'h0F, w);
    data = 8'hFF;
    run_frame(8'h0F, "f0F", 0, 0);
    @(negedge clk);
    stb = 1'b0;
    run_frame(8'hFF, "fFF", 0, 0);

    // Random bytes with random idle gaps.
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      start_byte(rb, w);
      stb = 1'b0;
      run_frame(rb, "frnd", 0, 0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    // 5: reset is asserted asynchronously during data bit 3. The line goes high and busy drops before the next edge.
    rb = 8'($urandom);
    start_byte(rb, w);
    stb = 1'b0;
    for (int unsigned k = 0; k < 4 * CPB + 1; k++) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_line", uart_tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_byte(8'hC3, w);
    stb = 1'b0;
    run_frame(8'hC3, "fC3", 0, 0);

`ifdef HBTXUART_CTS_EN
    // 6: CTS blocks in IDLE. Releasing it reaches busy 3 clocks later, and raising it mid-frame does not stop the frame.
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    stb  = 1'b1;
    data = 8'h33;
    for (int k = 0; k < 50; k++) begin
      chk("cts_block_line", uart_tx, 1'b1);
      chk("cts_block_busy", busy, 1'b1);
      @(negedge clk);
    end
    cts_n = 1'b0;
    @(negedge clk); chk("cts_rel1", busy, 1'b1);
    @(negedge clk); chk("cts_rel2", busy, 1'b1);
    @(negedge clk); chk("cts_rel3", busy, 1'b0);
    @(negedge clk);
    stb = 1'b0;
    run_frame(8'h33, "f33", 8, 20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
